// File: rtl/alu_issue_if.sv
// Decode-to-EX issue bus for alu_issue: upstream instruction fields plus the registered EX-side results.
// The master side belongs to decode/EX, and the slave side belongs to the issue stage.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [4:0]  in_rs1_idx;
  logic [4:0]  in_rs2_idx;
  logic [4:0]  in_rd;
  logic [63:0] in_rs1_val;
  logic [63:0] in_rs2_val;
  logic [63:0] in_imm;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [3:0]  ALUcontrol;
  logic [63:0] store_data;
  logic [4:0]  out_rd;
  logic        memread;
  logic        memwrite;
  logic        regwrite;
  logic        branch;
  logic        illegal;
  logic [15:0] stall_count;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1_idx, in_rs2_idx, in_rd,
           in_rs1_val, in_rs2_val, in_imm, flush, out_ready,
    input  in_ready, out_valid, rs1, rs2, ALUcontrol, store_data, out_rd,
           memread, memwrite, regwrite, branch, illegal, stall_count
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1_idx, in_rs2_idx, in_rd,
           in_rs1_val, in_rs2_val, in_imm, flush, out_ready,
    output in_ready, out_valid, rs1, rs2, ALUcontrol, store_data, out_rd,
           memread, memwrite, regwrite, branch, illegal, stall_count
  );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: decodes one RV64 integer/ld/sd/beq instruction into a registered EX bundle.
// It also inserts a one-cycle bubble on a load-use hazard against the held load.
module alu_issue (
  input  logic   clk,
  input  logic   reset,
  alu_issue_if.slave bus
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  logic        out_valid_reg;
  logic [63:0] rs1_reg;
  logic [63:0] rs2_reg;
  logic [3:0]  alu_reg;
  logic [63:0] store_reg;
  logic [4:0]  rd_reg;
  logic        memread_reg;
  logic        memwrite_reg;
  logic        regwrite_reg;
  logic        branch_reg;
  logic        illegal_reg;
  logic [15:0] stall_reg;

  logic [3:0]  alu_next;
  logic [63:0] rs2_next;
  logic [63:0] store_next;
  logic        memread_next;
  logic        memwrite_next;
  logic        regwrite_next;
  logic        branch_next;
  logic        illegal_next;

  logic        uses_rs2;
  logic        hazard;
  logic        in_ready;
  logic        load;

  always_comb begin
    alu_next      = ALU_ADD;
    rs2_next      = bus.in_rs2_val;
    store_next    = 64'd0;
    memread_next  = 1'b0;
    memwrite_next = 1'b0;
    regwrite_next = 1'b0;
    branch_next   = 1'b0;
    illegal_next  = 1'b0;
    case (bus.in_opcode)
      OP_REG: begin
        regwrite_next = 1'b1;
        case (bus.in_funct3)
          3'b000:  alu_next = bus.in_funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_next = ALU_AND;
          3'b110:  alu_next = ALU_OR;
          default: illegal_next = 1'b1;
        endcase
      end
      OP_IMM: begin
        rs2_next      = bus.in_imm;
        regwrite_next = 1'b1;
        case (bus.in_funct3)
          3'b000:  alu_next = ALU_ADD;
          3'b111:  alu_next = ALU_AND;
          3'b110:  alu_next = ALU_OR;
          default: illegal_next = 1'b1;
        endcase
      end
      OP_LOAD: begin
        rs2_next      = bus.in_imm;
        memread_next  = 1'b1;
        regwrite_next = 1'b1;
        illegal_next  = (bus.in_funct3 != 3'b011);
      end
      OP_STORE: begin
        rs2_next      = bus.in_imm;
        store_next    = bus.in_rs2_val;
        memwrite_next = 1'b1;
        illegal_next  = (bus.in_funct3 != 3'b011);
      end
      OP_BRANCH: begin
        alu_next     = ALU_SUB;
        branch_next  = 1'b1;
        illegal_next = (bus.in_funct3 != 3'b000);
      end
      default: illegal_next = 1'b1;
    endcase
    // Illegal encodings still flow downstream, but they must not have side effects.
    if (illegal_next) begin
      alu_next      = ALU_ADD;
      store_next    = 64'd0;
      memread_next  = 1'b0;
      memwrite_next = 1'b0;
      regwrite_next = 1'b0;
      branch_next   = 1'b0;
    end
    if (bus.in_rd == 5'd0) begin
      regwrite_next = 1'b0;
    end
  end

  // I-type encodings carry immediate bits in the rs2 field, so only R/S/B formats compare it.
  assign uses_rs2 = (bus.in_opcode == OP_REG) || (bus.in_opcode == OP_STORE) ||
                    (bus.in_opcode == OP_BRANCH);

  assign hazard = out_valid_reg && memread_reg && (rd_reg != 5'd0) && bus.in_valid &&
                  ((bus.in_rs1_idx == rd_reg) || (uses_rs2 && (bus.in_rs2_idx == rd_reg)));

  assign in_ready = (!out_valid_reg || bus.out_ready) && !hazard && !bus.flush;
  assign load     = bus.in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      rs1_reg       <= 64'd0;
      rs2_reg       <= 64'd0;
      alu_reg       <= 4'b0000;
      store_reg     <= 64'd0;
      rd_reg        <= 5'd0;
      memread_reg   <= 1'b0;
      memwrite_reg  <= 1'b0;
      regwrite_reg  <= 1'b0;
      branch_reg    <= 1'b0;
      illegal_reg   <= 1'b0;
      stall_reg     <= 16'd0;
    end else begin
      if (bus.flush) begin
        out_valid_reg <= 1'b0;
      end else if (load) begin
        out_valid_reg <= 1'b1;
        rs1_reg       <= bus.in_rs1_val;
        rs2_reg       <= rs2_next;
        alu_reg       <= alu_next;
        store_reg     <= store_next;
        rd_reg        <= bus.in_rd;
        memread_reg   <= memread_next;
        memwrite_reg  <= memwrite_next;
        regwrite_reg  <= regwrite_next;
        branch_reg    <= branch_next;
        illegal_reg   <= illegal_next;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
      // A bubble cycle is one where the held load leaves while its consumer waits.
      if (hazard && bus.out_ready && !bus.flush && (stall_reg != 16'hFFFF)) begin
        stall_reg <= stall_reg + 16'd1;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_reg;
  assign bus.rs1         = rs1_reg;
  assign bus.rs2         = rs2_reg;
  assign bus.ALUcontrol  = alu_reg;
  assign bus.store_data  = store_reg;
  assign bus.out_rd      = rd_reg;
  assign bus.memread     = memread_reg;
  assign bus.memwrite    = memwrite_reg;
  assign bus.regwrite    = regwrite_reg;
  assign bus.branch      = branch_reg;
  assign bus.illegal     = illegal_reg;
  assign bus.stall_count = stall_reg;

endmodule
